version_select_store: RTL and testbench
=======================================

Name: version_select_store

Overview:
- Parametrised successor to the 4-input version priority router, for the multi-version memory datapath.
- Holds up to NUM_SLOTS (version, data) entries internally. Unlike the router, it does not take them on external ports.
- Answers registered read queries with the data of the newest stored version strictly less than the read version.
- Adds write insertion with in-place overwrite, eviction of the oldest entry when full, bulk pruning of stale versions, and a hit/miss flag (the router had no defined miss output).

Parameters:
- NUM_SLOTS, 8, number of version slots (>=2).
- BLOCK_SIZE, 4, version tag width in bits; versions compare as unsigned.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wrValid  input  1  write request.
- wrReady  output  1  write accepted when wrValid && wrReady; combinational, equals !pruneValid.
- wrVersion  input  BLOCK_SIZE  version tag of write.
- wrData  input  DATA_WIDTH  data of write.
- wrDropped  output  1  registered one-cycle pulse: an accepted write was discarded.
- pruneValid  input  1  prune request, single cycle, always accepted.
- pruneVersion  input  BLOCK_SIZE  entries with version < pruneVersion are invalidated.
- rdValid  input  1  read query, always accepted.
- rdVersion  input  BLOCK_SIZE  read version.
- rdRespValid  output  1  response valid, exactly one cycle after rdValid.
- rdHit  output  1  a qualifying entry was found.
- rdData  output  DATA_WIDTH  data of selected entry; 0 on miss.
- rdHitVersion  output  BLOCK_SIZE  version of selected entry; 0 on miss.
- count  output  $clog2(NUM_SLOTS+1)  number of valid slots, registered.

Behaviour:
- Reset (rst=1 at an edge):
  - all slot valid bits cleared;
  - count, rdRespValid, rdHit, rdData, rdHitVersion and wrDropped all go to 0;
  - reset overrides every request in that cycle; a read issued in the reset cycle produces no response.
- Read, latency 1:
  - at an edge with rdValid=1, search valid slots for the maximum version v with v < rdVersion, unsigned and strict;
  - register rdRespValid=1, rdHit=1, rdData and rdHitVersion of that slot;
  - if no slot qualifies: rdHit=0, rdData=0, rdHitVersion=0, rdRespValid=1;
  - rdRespValid=0 in any cycle after rdValid=0; rdData and rdHitVersion hold their last value in that case;
  - rdVersion=0 always misses;
  - back-to-back reads give one response per cycle.
- Read/update ordering: reads observe slot state before any write or prune in the same cycle (read-before-write).
- Write, on an accepted write:
  - if a valid slot holds wrVersion, overwrite its data; count unchanged.
  - else if a free slot exists, fill the lowest-index free slot; count+1.
  - else, when full:
    - if wrVersion > the minimum stored version, replace the slot holding the minimum; count unchanged.
    - otherwise discard the write and pulse wrDropped=1 on the next cycle.
- Version uniqueness: stored versions are always unique, because duplicates overwrite. Min/max search needs no tie rule beyond lowest index as a safety default.
- Prune:
  - clears the valid bit of every slot with version < pruneVersion;
  - count is updated to the post-prune occupancy on the same edge;
  - pruneVersion=0 is a no-op.
- Prune/write collision: wrReady=0 while pruneValid=1, so no write commits in a prune cycle. The writer must hold wrValid until accepted.
- Version wrap-around: not handled. Versions are monotonic within a lifetime, and the owner issues a prune or reset before the tag width wraps.

Test Plan:
- Reset, then read rdVersion=5 -> one cycle later rdRespValid=1, rdHit=0, rdData=0, count=0.
- Write (1,0xA),(3,0xB),(6,0xC); read 5 -> rdHit=1, rdData=0xB, rdHitVersion=3. Read 7 -> 0xC. Read 1 -> miss. Read 0 -> miss.
- Write (3,0xD) after the above -> count stays 3; read 4 -> rdData=0xD.
- NUM_SLOTS=8:
  - fill with versions 2..9, then write (12,0xE) -> version 2 evicted, count=8, read 3 -> miss, read 15 -> 0xE;
  - then write (1,0xF) -> wrDropped=1 for one cycle, contents unchanged.
- Versions 2,4,6,8 stored; pruneValid with pruneVersion=5 while wrValid=1 (11,0x1):
  - wrReady=0 that cycle, count=2 next cycle, read 5 -> miss;
  - write accepted the following cycle, count=3.
- Read 7 in the same cycle as write (6,0x2) with only version 4 stored -> response is version 4's data; a read 7 in the next cycle returns 0x2.
- Assert rst mid-stream with rdValid=1 -> no response for that read; all outputs 0; count=0 next cycle.

Source files
------------

// File: rtl/version_select_store.sv
// version_select_store: small multi-version store. Keeps up to NUM_SLOTS
// (version, data) entries and answers registered "newest version strictly
// below rdVersion" queries. Supports in-place overwrite, eviction of the
// oldest entry when full, and bulk pruning of stale versions.
module version_select_store #(
    parameter int NUM_SLOTS  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wrValid,
    output logic                            wrReady,
    input  logic [BLOCK_SIZE-1:0]           wrVersion,
    input  logic [DATA_WIDTH-1:0]           wrData,
    output logic                            wrDropped,
    input  logic                            pruneValid,
    input  logic [BLOCK_SIZE-1:0]           pruneVersion,
    input  logic                            rdValid,
    input  logic [BLOCK_SIZE-1:0]           rdVersion,
    output logic                            rdRespValid,
    output logic                            rdHit,
    output logic [DATA_WIDTH-1:0]           rdData,
    output logic [BLOCK_SIZE-1:0]           rdHitVersion,
    output logic [$clog2(NUM_SLOTS+1)-1:0]  count
);

    localparam int IW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(NUM_SLOTS+1);

    logic [NUM_SLOTS-1:0]  slot_valid;
    logic [NUM_SLOTS-1:0]  valid_next;
    logic [BLOCK_SIZE-1:0] slot_ver  [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] slot_data [NUM_SLOTS];

    logic                  rd_found;
    logic [IW-1:0]         rd_idx;
    logic [BLOCK_SIZE-1:0] rd_best;

    logic                  match_found;
    logic [IW-1:0]         match_idx;
    logic                  free_found;
    logic [IW-1:0]         free_idx;
    logic [IW-1:0]         min_idx;
    logic [BLOCK_SIZE-1:0] min_ver;

    logic                  wr_fire;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic                  wr_drop;
    logic [CW-1:0]         count_next;

    // A prune owns the cycle; writers must wait it out.
    assign wrReady = !pruneValid;
    assign wr_fire = wrValid && wrReady;

    // Read search on the pre-update slot state: largest valid version below rdVersion.
    always_comb begin
        rd_found = 1'b0;
        rd_idx   = '0;
        rd_best  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid[i] && (slot_ver[i] < rdVersion) &&
                (!rd_found || (slot_ver[i] > rd_best))) begin
                rd_found = 1'b1;
                rd_idx   = IW'(i);
                rd_best  = slot_ver[i];
            end
        end
    end

    // Write-side lookups: matching version, lowest free slot, oldest valid slot.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        min_idx     = '0;
        min_ver     = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid[i] && (slot_ver[i] == wrVersion) && !match_found) begin
                match_found = 1'b1;
                match_idx   = IW'(i);
            end
            if (!slot_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            // Scanning downward with <= leaves the lowest index on a tie.
            if (slot_valid[i] && (slot_ver[i] <= min_ver)) begin
                min_idx = IW'(i);
                min_ver = slot_ver[i];
            end
        end
    end

    // Update decision: prune, or place/overwrite/evict/drop an accepted write.
    always_comb begin
        valid_next = slot_valid;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_drop    = 1'b0;
        if (pruneValid) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_ver[i] < pruneVersion) begin
                    valid_next[i] = 1'b0;
                end
            end
        end else if (wr_fire) begin
            if (match_found) begin
                wr_en  = 1'b1;
                wr_idx = match_idx;
            end else if (free_found) begin
                wr_en                = 1'b1;
                wr_idx               = free_idx;
                valid_next[free_idx] = 1'b1;
            end else if (wrVersion > min_ver) begin
                wr_en  = 1'b1;
                wr_idx = min_idx;
            end else begin
                wr_drop = 1'b1;
            end
        end
        count_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_next = count_next + CW'(valid_next[i]);
        end
    end

    // Slot valid bits and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            count      <= '0;
        end else begin
            slot_valid <= valid_next;
            count      <= count_next;
        end
    end

    // Slot payload storage; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            slot_ver[wr_idx]  <= wrVersion;
            slot_data[wr_idx] <= wrData;
        end
    end

    // Registered read response and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdRespValid  <= 1'b0;
            rdHit        <= 1'b0;
            rdData       <= '0;
            rdHitVersion <= '0;
            wrDropped    <= 1'b0;
        end else begin
            rdRespValid <= rdValid;
            wrDropped   <= wr_drop;
            if (rdValid) begin
                rdHit        <= rd_found;
                rdData       <= rd_found ? slot_data[rd_idx] : '0;
                rdHitVersion <= rd_found ? slot_ver[rd_idx]  : '0;
            end
        end
    end

endmodule

// File: tb/tb_version_select_store.sv
// Bench for version_select_store: directed vector table plus randomized
// traffic, both checked against a version-keyed associative-array model.
module tb_version_select_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrValid;
    logic        wrReady;
    logic [3:0]  wrVersion;
    logic [31:0] wrData;
    logic        wrDropped;
    logic        pruneValid;
    logic [3:0]  pruneVersion;
    logic        rdValid;
    logic [3:0]  rdVersion;
    logic        rdRespValid;
    logic        rdHit;
    logic [31:0] rdData;
    logic [3:0]  rdHitVersion;
    logic [3:0]  count;

    version_select_store #(.NUM_SLOTS(8), .BLOCK_SIZE(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wrValid(wrValid), .wrReady(wrReady), .wrVersion(wrVersion), .wrData(wrData),
        .wrDropped(wrDropped),
        .pruneValid(pruneValid), .pruneVersion(pruneVersion),
        .rdValid(rdValid), .rdVersion(rdVersion),
        .rdRespValid(rdRespValid), .rdHit(rdHit), .rdData(rdData),
        .rdHitVersion(rdHitVersion), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: stored entries keyed by version.
    logic [31:0] mdl [int];
    logic        e_hit  = 1'b0;
    logic [31:0] e_data = '0;
    logic [3:0]  e_hv   = '0;

    typedef struct {
        logic rst; logic wv; logic [3:0] wver; logic [31:0] wdata;
        logic pv; logic [3:0] pver; logic rv; logic [3:0] rver;
        logic x_ready; logic x_resp; logic x_hit; logic [31:0] x_data;
        logic [3:0] x_hv; logic [3:0] x_cnt; logic x_drop;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic wv, input int wver, input int wdata,
                       input logic pv, input int pver, input logic rv, input int rver,
                       input logic xr, input logic xs, input logic xh, input int xd,
                       input int xhv, input int xc, input logic xdr);
        vec_t v;
        v.rst = r; v.wv = wv; v.wver = 4'(wver); v.wdata = 32'(wdata);
        v.pv = pv; v.pver = 4'(pver); v.rv = rv; v.rver = 4'(rver);
        v.x_ready = xr; v.x_resp = xs; v.x_hit = xh; v.x_data = 32'(xd);
        v.x_hv = 4'(xhv); v.x_cnt = 4'(xc); v.x_drop = xdr;
        vecs.push_back(v);
    endtask

    // One clock: predict from the model, advance, compare, update.
    task automatic do_cycle();
        logic x_resp;
        logic x_drop;
        int   best;
        int   mn;
        int   wv;
        #1;
        chk("wrReady", wrReady, !pruneValid);
        x_resp = 1'b0;
        x_drop = 1'b0;
        if (rst) begin
            mdl.delete();
            e_hit = 1'b0; e_data = '0; e_hv = '0;
        end else begin
            if (rdValid) begin
                x_resp = 1'b1;
                best   = -1;
                foreach (mdl[k]) if (k < int'(rdVersion) && k > best) best = k;
                e_hit  = (best >= 0);
                e_data = (best >= 0) ? mdl[best] : 32'h0;
                e_hv   = (best >= 0) ? 4'(best) : 4'h0;
            end
            if (pruneValid) begin
                int dead[$];
                foreach (mdl[k]) if (k < int'(pruneVersion)) dead.push_back(k);
                foreach (dead[j]) mdl.delete(dead[j]);
            end else if (wrValid) begin
                wv = int'(wrVersion);
                if (mdl.exists(wv) || mdl.num() < 8) begin
                    mdl[wv] = wrData;
                end else begin
                    mn = 1000;
                    foreach (mdl[k]) if (k < mn) mn = k;
                    if (wv > mn) begin
                        mdl.delete(mn);
                        mdl[wv] = wrData;
                    end else begin
                        x_drop = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rdRespValid", rdRespValid, x_resp);
        if (x_resp) chk("rdHit", rdHit, e_hit);
        chk("rdData", rdData, e_data);
        chk("rdHitVersion", rdHitVersion, e_hv);
        chk("count", count, mdl.num());
        chk("wrDropped", wrDropped, x_drop);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; wrValid = v.wv; wrVersion = v.wver; wrData = v.wdata;
        pruneValid = v.pv; pruneVersion = v.pver; rdValid = v.rv; rdVersion = v.rver;
    endtask

    initial begin
        rst = 1'b1; wrValid = 0; wrVersion = 0; wrData = 0;
        pruneValid = 0; pruneVersion = 0; rdValid = 0; rdVersion = 0;

        // rst wv wver wdata pv pver rv rver | ready resp hit data hv cnt drop
        add(1,0,0,0,    0,0,0,0,  1,0,0,0,0,0,0);
        add(0,0,0,0,    0,0,1,5,  1,1,0,0,0,0,0);
        add(0,1,1,'hA,  0,0,0,0,  1,0,0,0,0,1,0);
        add(0,1,3,'hB,  0,0,0,0,  1,0,0,0,0,2,0);
        add(0,1,6,'hC,  0,0,0,0,  1,0,0,0,0,3,0);
        add(0,0,0,0,    0,0,1,5,  1,1,1,'hB,3,3,0);
        add(0,0,0,0,    0,0,1,7,  1,1,1,'hC,6,3,0);
        add(0,0,0,0,    0,0,1,1,  1,1,0,0,0,3,0);
        add(0,0,0,0,    0,0,1,0,  1,1,0,0,0,3,0);
        add(0,1,3,'hD,  0,0,0,0,  1,0,0,0,0,3,0);
        add(0,0,0,0,    0,0,1,4,  1,1,1,'hD,3,3,0);
        add(1,0,0,0,    0,0,0,0,  1,0,0,0,0,0,0);
        for (int v = 2; v <= 9; v++)
            add(0,1,v,'h20+v, 0,0,0,0, 1,0,0,0,0,v-1,0);
        add(0,1,12,'hE, 0,0,0,0,  1,0,0,0,0,8,0);
        add(0,0,0,0,    0,0,1,3,  1,1,0,0,0,8,0);
        add(0,0,0,0,    0,0,1,15, 1,1,1,'hE,12,8,0);
        add(0,1,1,'hF,  0,0,0,0,  1,0,0,'hE,12,8,1);
        add(0,0,0,0,    0,0,0,0,  1,0,0,'hE,12,8,0);
        add(0,0,0,0,    0,0,1,10, 1,1,1,'h29,9,8,0);
        add(0,0,0,0,    0,0,1,3,  1,1,0,0,0,8,0);
        add(1,0,0,0,    0,0,0,0,  1,0,0,0,0,0,0);
        for (int v = 2; v <= 8; v += 2)
            add(0,1,v,'h40+v, 0,0,0,0, 1,0,0,0,0,v/2,0);
        add(0,1,11,1,   1,5,0,0,  0,0,0,0,0,2,0);
        add(0,1,11,1,   0,0,1,5,  1,1,0,0,0,3,0);
        add(0,0,0,0,    0,0,1,12, 1,1,1,1,11,3,0);
        add(1,0,0,0,    0,0,0,0,  1,0,0,0,0,0,0);
        add(0,1,4,'h44, 0,0,0,0,  1,0,0,0,0,1,0);
        add(0,1,6,2,    0,0,1,7,  1,1,1,'h44,4,2,0);
        add(0,0,0,0,    0,0,1,7,  1,1,1,2,6,2,0);
        add(0,1,9,'h99, 0,0,0,0,  1,0,0,2,6,3,0);
        add(1,0,0,0,    0,0,1,7,  1,0,0,0,0,0,0);
        add(0,0,0,0,    0,0,1,7,  1,1,0,0,0,0,0);
        add(0,1,3,'h33, 0,0,0,0,  1,0,0,0,0,1,0);
        add(0,0,0,0,    1,0,0,0,  0,0,0,0,0,1,0);
        add(0,0,0,0,    0,0,1,4,  1,1,1,'h33,3,1,0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            do_cycle();
            chk($sformatf("tbl%0d_ready", i), wrReady, vecs[i].x_ready);
            chk($sformatf("tbl%0d_resp", i), rdRespValid, vecs[i].x_resp);
            if (vecs[i].x_resp) chk($sformatf("tbl%0d_hit", i), rdHit, vecs[i].x_hit);
            chk($sformatf("tbl%0d_data", i), rdData, vecs[i].x_data);
            chk($sformatf("tbl%0d_hv", i), rdHitVersion, vecs[i].x_hv);
            chk($sformatf("tbl%0d_count", i), count, vecs[i].x_cnt);
            chk($sformatf("tbl%0d_drop", i), wrDropped, vecs[i].x_drop);
        end

        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            wrValid      = $urandom_range(0, 1);
            wrVersion    = 4'($urandom_range(0, 15));
            wrData       = $urandom;
            pruneValid   = ($urandom_range(0, 11) == 0);
            pruneVersion = 4'($urandom_range(0, 15));
            rdValid      = $urandom_range(0, 1);
            rdVersion    = 4'($urandom_range(0, 15));
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
